data_sampling_mv: RTL and testbench

// - Parametrised oversampling bit recoverer for the UART RX path; successor to the fixed 3-vote sampler.
// - Synchronises serial data_in and takes 3 or 5 votes centred on the bit midpoint.
// - Emits the majority bit with a 1-cycle valid strobe and a noise flag when the votes disagree.
// - Sits between the edge/bit counters and the RX FSM (start/parity/stop checks, deserialiser).

---
 rtl/data_sampling_mv_if.sv | 27 ++
 rtl/data_sampling_mv.sv | 172 +++++++++++++++++
 tb/tb_data_sampling_mv.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/data_sampling_mv_if.sv
// data_sampling_mv_if
// Bundles the sampler's control/data inputs and its voted-bit outputs.
//   master : drives sample_en, prescale, vote_mode, edge_counter, data_in;
//            observes sampled_bit, sample_valid, noise_flag
//   slave  : the sampler itself (opposite directions)
interface data_sampling_mv_if #(
    parameter int EDGE_CNT_W = 6
);
    logic                  sample_en;
    logic [1:0]            prescale;
    logic                  vote_mode;
    logic [EDGE_CNT_W-1:0] edge_counter;
    logic                  data_in;
    logic                  sampled_bit;
    logic                  sample_valid;
    logic                  noise_flag;

    modport master (
        output sample_en, prescale, vote_mode, edge_counter, data_in,
        input  sampled_bit, sample_valid, noise_flag
    );

    modport slave (
        input  sample_en, prescale, vote_mode, edge_counter, data_in,
        output sampled_bit, sample_valid, noise_flag
    );
endinterface

// File: rtl/data_sampling_mv.sv
// data_sampling_mv
// Oversampling bit recoverer for the UART RX path. The raw line is passed
// through an optional synchroniser, then 3 or 5 votes centred on the bit
// midpoint are majority-decided. The result is presented with a 1-cycle
// valid strobe and a noise flag raised when the votes were not unanimous
// (or when a vote edge was skipped).
// Ports:
//   clock : oversampling clock
//   reset : asynchronous active-low reset
//   bus   : data_sampling_mv_if.slave
//           in : sample_en, prescale (00=x8 01=x16 10=x32 11=x4),
//                vote_mode (0=3 votes, 1=5 votes; x4 always 3 votes),
//                edge_counter, data_in
//           out: sampled_bit, sample_valid, noise_flag (all registered)
module data_sampling_mv #(
    parameter int EDGE_CNT_W  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    data_sampling_mv_if.slave   bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Midpoint edge of a bit for the selected oversampling factor.
    function automatic logic [EDGE_CNT_W-1:0] centre_f(input logic [1:0] ps);
        logic [EDGE_CNT_W-1:0] c;
        case (ps)
            2'b00:   c = EDGE_CNT_W'(32'd4);
            2'b01:   c = EDGE_CNT_W'(32'd8);
            2'b10:   c = EDGE_CNT_W'(32'd16);
            2'b11:   c = EDGE_CNT_W'(32'd2);
            default: c = EDGE_CNT_W'(32'd4);
        endcase
        return c;
    endfunction

    // Half-width of the vote window; x4 has no room for 5 votes.
    function automatic logic [1:0] half_f(input logic [1:0] ps, input logic vm);
        logic [1:0] h;
        if (ps == 2'b11 || vm == 1'b0) begin
            h = 2'd1;
        end else begin
            h = 2'd2;
        end
        return h;
    endfunction

    logic                  ds_s;
    logic [1:0]            h_live_s;
    logic [EDGE_CNT_W-1:0] c_live_s;
    logic [EDGE_CNT_W-1:0] lo_live_s;
    logic [EDGE_CNT_W-1:0] hi_live_s;
    logic [2:0]            ones_next_s;
    logic [2:0]            vote_next_s;
    logic [2:0]            full_s;

    state_t                state_r;
    logic [EDGE_CNT_W-1:0] lo_r;
    logic [EDGE_CNT_W-1:0] hi_r;
    logic [1:0]            h_r;
    logic [2:0]            ones_cnt_r;
    logic [2:0]            vote_cnt_r;
    logic                  sampled_bit_r;
    logic                  sample_valid_r;
    logic                  noise_flag_r;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ds_s = bus.data_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_r;

            // Shift the raw line through the synchroniser; idle-high after reset.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sync_r <= {SYNC_STAGES{1'b1}};
                end else begin
                    sync_r[0] <= bus.data_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_r[i] <= sync_r[i-1];
                    end
                end
            end

            assign ds_s = sync_r[SYNC_STAGES-1];
        end
    endgenerate

    // Window geometry from the live settings plus next-count values.
    always_comb begin
        h_live_s    = half_f(bus.prescale, bus.vote_mode);
        c_live_s    = centre_f(bus.prescale);
        lo_live_s   = c_live_s - EDGE_CNT_W'(h_live_s);
        hi_live_s   = c_live_s + EDGE_CNT_W'(h_live_s);
        ones_next_s = ones_cnt_r + {2'b00, ds_s};
        vote_next_s = vote_cnt_r + 3'd1;
        // Number of votes a complete window holds: 2h+1.
        full_s      = {h_r, 1'b0} + 3'd1;
    end

    // Window FSM: open on the first vote edge, accumulate, decide on the last.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            lo_r           <= {EDGE_CNT_W{1'b0}};
            hi_r           <= {EDGE_CNT_W{1'b0}};
            h_r            <= 2'd1;
            ones_cnt_r     <= 3'd0;
            vote_cnt_r     <= 3'd0;
            sampled_bit_r  <= 1'b1;
            sample_valid_r <= 1'b0;
            noise_flag_r   <= 1'b0;
        end else begin
            sample_valid_r <= 1'b0;
            if (!bus.sample_en) begin
                state_r    <= IDLE;
                ones_cnt_r <= 3'd0;
                vote_cnt_r <= 3'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (bus.edge_counter == lo_live_s) begin
                            // Geometry is frozen here so mid-window setting
                            // changes only take effect on the next bit.
                            state_r    <= COLLECT;
                            lo_r       <= lo_live_s;
                            hi_r       <= hi_live_s;
                            h_r        <= h_live_s;
                            ones_cnt_r <= {2'b00, ds_s};
                            vote_cnt_r <= 3'd1;
                        end
                    end
                    COLLECT: begin
                        if (bus.edge_counter == {EDGE_CNT_W{1'b0}}) begin
                            // Bit counter restarted under us: drop the window silently.
                            state_r    <= IDLE;
                            ones_cnt_r <= 3'd0;
                            vote_cnt_r <= 3'd0;
                        end else if (bus.edge_counter > lo_r && bus.edge_counter < hi_r) begin
                            ones_cnt_r <= ones_next_s;
                            vote_cnt_r <= vote_next_s;
                        end else if (bus.edge_counter == hi_r) begin
                            state_r        <= IDLE;
                            ones_cnt_r     <= 3'd0;
                            vote_cnt_r     <= 3'd0;
                            sampled_bit_r  <= (ones_next_s > {1'b0, h_r});
                            // A missing vote (skipped edge) is always reported as noise.
                            noise_flag_r   <= (ones_next_s != 3'd0 && ones_next_s != full_s) ||
                                              (vote_next_s != full_s);
                            sample_valid_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        ones_cnt_r <= 3'd0;
                        vote_cnt_r <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign bus.sampled_bit  = sampled_bit_r;
    assign bus.sample_valid = sample_valid_r;
    assign bus.noise_flag   = noise_flag_r;

endmodule

// File: tb/tb_data_sampling_mv.sv
// tb_data_sampling_mv
// Drives whole bits (edge_counter 0..P-1) with directed and random line
// patterns. A reference model records the synchronised line at each edge,
// works out the vote window from the oversampling factor and pushes the
// expected {bit, noise} into a scoreboard queue; a monitor pops and compares
// on every sample_valid and checks that outputs hold between strobes.
module tb_data_sampling_mv;
    localparam int W = 6;
    localparam int S = 2;

    typedef struct {
        logic b;
        logic n;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    logic din_hist[$];
    logic last_bit   = 1'b1;
    logic last_noise = 1'b0;
    logic mon_on     = 1'b0;
    exp_t mon_e;

    always #5 clock = ~clock;

    data_sampling_mv_if #(.EDGE_CNT_W(W)) bus ();

    data_sampling_mv #(.EDGE_CNT_W(W), .SYNC_STAGES(S)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare on every strobe, otherwise outputs must hold.
    always @(negedge clock) begin
        if (reset && mon_on) begin
            if (bus.sample_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: got strobe, expected none at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sampled_bit", bus.sampled_bit, mon_e.b);
                    check("noise_flag", bus.noise_flag, mon_e.n);
                    last_bit   = mon_e.b;
                    last_noise = mon_e.n;
                end
            end else begin
                check("hold_bit", bus.sampled_bit, last_bit);
                check("hold_noise", bus.noise_flag, last_noise);
            end
        end
    end

    // Oversampling factor, midpoint and half-width straight from the rules.
    task automatic geom(input logic [1:0] ps, input logic vm,
                        output int p, output int c, output int h);
        p = (ps == 2'd0) ? 8 : (ps == 2'd1) ? 16 : (ps == 2'd2) ? 32 : 4;
        c = p / 2;
        h = (ps == 2'd3 || !vm) ? 1 : 2;
    endtask

    // One clock of stimulus; returns the synchronised line the DUT will vote on.
    task automatic drive(input logic en, input logic [1:0] ps, input logic vm,
                         input int ec, input logic din, output logic ds);
        @(negedge clock);
        bus.sample_en    = en;
        bus.prescale     = ps;
        bus.vote_mode    = vm;
        bus.edge_counter = W'(ec);
        bus.data_in      = din;
        din_hist.push_back(din);
        ds = din_hist[din_hist.size() - 1 - S];
    endtask

    task automatic prefill();
        din_hist.delete();
        for (int i = 0; i < S; i++) din_hist.push_back(1'b1);
    endtask

    // One bit period. 'want' is the line value intended at each edge after the
    // synchroniser, so data_in is driven S edges early. drop_at: first edge
    // with sample_en low; change_at: first edge showing ps_after; skip: edge
    // value never presented. Negative disables each option.
    task automatic send_bit(input logic [1:0] ps, input logic vm, input logic [31:0] want,
                            input int drop_at, input logic [1:0] ps_after,
                            input int change_at, input int skip);
        int p, c, h, lo, hi, ones, votes;
        logic ds, en, din, aborted;
        logic [1:0] psv;
        geom(ps, vm, p, c, h);
        lo = c - h;
        hi = c + h;
        ones = 0;
        votes = 0;
        aborted = 1'b0;
        for (int e = 0; e < p; e++) begin
            if (e == skip) continue;
            en  = !(drop_at >= 0 && e >= drop_at);
            psv = (change_at >= 0 && e >= change_at) ? ps_after : ps;
            din = (e + S < p) ? want[e + S] : 1'b1;
            drive(en, psv, vm, e, din, ds);
            if (!en) aborted = 1'b1;
            if (e >= lo && e <= hi) begin
                ones += int'(ds);
                votes++;
            end
            if (e == hi && !aborted) begin
                exp_q.push_back('{b: (ones > h),
                                  n: ((ones != 0 && ones != votes) || votes != 2 * h + 1)});
            end
        end
    endtask

    initial begin
        logic ds;
        logic [31:0] line;
        int p, c, h, sel;
        logic [1:0] ps;
        logic vm, base;

        bus.sample_en = 1'b0;
        bus.prescale = 2'd0;
        bus.vote_mode = 1'b0;
        bus.edge_counter = '0;
        bus.data_in = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_bit", bus.sampled_bit, 1'b1);
        check("reset_valid", bus.sample_valid, 1'b0);
        check("reset_noise", bus.noise_flag, 1'b0);
        prefill();
        reset = 1'b1;
        mon_on = 1'b1;

        // Steady 0, x8 3 votes.
        send_bit(2'd0, 1'b0, 32'h0000_0000, -1, 2'd0, -1, -1);
        // x16 5 votes, single glitch at edge 7.
        send_bit(2'd1, 1'b1, 32'h0000_0080, -1, 2'd1, -1, -1);
        // x32 5 votes, votes 1,1,0,1,0 at edges 14..18.
        send_bit(2'd2, 1'b1, 32'h0002_C000, -1, 2'd2, -1, -1);
        // x4 with 5 votes requested: forced to 3.
        send_bit(2'd3, 1'b1, 32'hFFFF_FFFF, -1, 2'd3, -1, -1);
        // Enable dropped mid-window, then a normal bit.
        send_bit(2'd0, 1'b0, 32'h0000_0000, 4, 2'd0, -1, -1);
        send_bit(2'd0, 1'b0, 32'h0000_0000, -1, 2'd0, -1, -1);
        // Prescale changes mid-window; next bits use x16.
        send_bit(2'd0, 1'b0, 32'hFFFF_FFFF, -1, 2'd1, 4, -1);
        send_bit(2'd1, 1'b0, 32'h0000_0100, -1, 2'd1, -1, -1);
        send_bit(2'd1, 1'b0, 32'h0000_0000, -1, 2'd1, -1, -1);
        // Skipped vote edge inside a 5-vote window.
        send_bit(2'd0, 1'b1, 32'hFFFF_FFFF, -1, 2'd0, -1, 4);

        // Random back-to-back bits with occasional drops and skipped edges.
        for (int n = 0; n < 60; n++) begin
            ps   = 2'($urandom_range(0, 3));
            vm   = 1'($urandom_range(0, 1));
            base = 1'($urandom_range(0, 1));
            for (int e = 0; e < 32; e++) begin
                line[e] = ($urandom_range(0, 4) == 0) ? ~base : base;
            end
            geom(ps, vm, p, c, h);
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                send_bit(ps, vm, line, $urandom_range(c - h, c + h), ps, -1, -1);
            end else if (sel == 1) begin
                send_bit(ps, vm, line, -1, ps, -1, $urandom_range(c - h + 1, c + h - 1));
            end else begin
                send_bit(ps, vm, line, -1, ps, -1, -1);
            end
        end

        // Known non-reset outputs, then async reset in the middle of a window.
        send_bit(2'd0, 1'b0, 32'h0000_0010, -1, 2'd0, -1, -1);
        for (int e = 0; e < 5; e++) drive(1'b1, 2'd0, 1'b0, e, 1'b1, ds);
        #2;
        reset = 1'b0;
        #1;
        check("async_bit", bus.sampled_bit, 1'b1);
        check("async_valid", bus.sample_valid, 1'b0);
        check("async_noise", bus.noise_flag, 1'b0);
        last_bit = 1'b1;
        last_noise = 1'b0;
        @(negedge clock);
        prefill();
        reset = 1'b1;
        send_bit(2'd1, 1'b0, 32'h0000_0000, -1, 2'd1, -1, -1);

        for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 1'b0, 0, 1'b1, ds);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_strobes: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
